// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, two write ports (B wins on
// collision) and a per-register busy scoreboard tracking issued producers.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             wea,
    input  logic [AW-1:0]    waa,
    input  logic [WIDTH-1:0] wda,
    input  logic             web,
    input  logic [AW-1:0]    wab,
    input  logic [WIDTH-1:0] wdb,
    input  logic             iss_v,
    input  logic [AW-1:0]    iss_dst,
    output logic             busy1,
    output logic             busy2,
    output logic [AW:0]      pend_cnt
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wa_ok;
    logic             wb_ok;
    logic             iss_ok;
    logic [AW:0]      cnt;

    // Address is writable/readable: inside the array and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !(ZERO_REG && (a == '0));
    endfunction

    assign wa_ok  = wea && addr_ok(waa);
    assign wb_ok  = web && addr_ok(wab);
    assign iss_ok = iss_v && addr_ok(iss_dst);

    function automatic logic wr_hit(input logic [AW-1:0] ra);
        return (wa_ok && (waa == ra)) || (wb_ok && (wab == ra));
    endfunction

    // Bypass order B, then A, then storage; storage reads as zero while in reset.
    function automatic logic [WIDTH-1:0] rd_mux(input logic [AW-1:0] ra);
        if (!addr_ok(ra))             return '0;
        if (wb_ok && (wab == ra))     return wdb;
        if (wa_ok && (waa == ra))     return wda;
        if (reset)                    return '0;
        return mem_q[ra];
    endfunction

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wa_ok) begin
            mem_d[waa]  = wda;
            busy_d[waa] = 1'b0;
        end
        if (wb_ok) begin
            mem_d[wab]  = wdb;
            busy_d[wab] = 1'b0;
        end
        // Issue applied last so a new producer supersedes a same-cycle writeback.
        if (iss_ok) begin
            busy_d[iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (AW+1)'(busy_q[i]);
        end
    end

    assign rd1      = rd_mux(ra1);
    assign rd2      = rd_mux(ra2);
    assign busy1    = !reset && addr_ok(ra1) && busy_q[ra1] && !wr_hit(ra1);
    assign busy2    = !reset && addr_ok(ra2) && busy_q[ra2] && !wr_hit(ra2);
    assign pend_cnt = reset ? '0 : cnt;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and data port, in bits.
REQ-002 Parameter DEPTH, default 32: number of registers; the address width is AW = $clog2(DEPTH).
REQ-003 Parameter ZERO_REG, default 1: when 1, register 0 reads as 0 and is never written or marked busy.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports listed clock first, then reset:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
REQ-005 The block SHALL provide two combinational read ports:
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  WIDTH  read data
REQ-006 The block SHALL provide write port A:
- wea  in  1  enable
- waa  in  AW  address
- wda  in  WIDTH  data
REQ-007 The block SHALL provide write port B:
- web  in  1  enable
- wab  in  AW  address
- wdb  in  WIDTH  data
REQ-008 The block SHALL provide the issue port:
- iss_v  in  1  issue strobe
- iss_dst  in  AW  destination register to mark pending
REQ-009 The block SHALL provide scoreboard status outputs:
- busy1, busy2  out  1  operand on ra1/ra2 not yet available
- pend_cnt  out  AW+1  number of registers currently pending

Function
REQ-010 Writes SHALL take effect at the rising edge of clk when the port enable is high.
REQ-011 When both write ports are enabled with the same address, port B's data SHALL be stored and port A's data discarded.
REQ-012 With ZERO_REG=1, writes to address 0 SHALL be ignored, and rd1/rd2 SHALL return 0 for address 0, bypass included.
REQ-013 Each read port SHALL bypass same-cycle write data, in this priority order:
- web && wab==ra → wdb
- else wea && waa==ra → wda
- else stored value
REQ-014 Any address >= DEPTH (non-power-of-2 DEPTH) SHALL read 0, and writes or issues to it SHALL be ignored.
REQ-015 The block SHALL hold a DEPTH-bit busy vector, where busy[i] means a producer has been issued and its writeback has not yet been seen.
REQ-016 At the clock edge, busy[i] SHALL be cleared when any enabled write port targets register i.
REQ-017 At the clock edge, busy[i] SHALL be set when iss_v is high and iss_dst==i.
REQ-018 When a set and a clear of the same busy bit occur in the same cycle, the set SHALL win, because the new producer supersedes the old one.
REQ-019 With ZERO_REG=1, an issue to register 0 SHALL be ignored and busy[0] SHALL remain 0.
REQ-020 busy1 SHALL equal busy[ra1] AND NOT(a write to ra1 in the current cycle); busy2 is defined the same way on ra2, so bypassed data is never reported busy.
REQ-021 pend_cnt SHALL equal the population count of the registered busy vector, SHALL be updated one cycle after an issue or writeback, and SHALL never exceed DEPTH.
REQ-022 A write to a register that is not busy SHALL update the data normally and leave the busy vector unchanged.
REQ-023 Repeated issues to an already busy register SHALL leave it busy and SHALL not change pend_cnt.

Reset
REQ-024 When reset is high at a clock edge, every register SHALL be cleared to 0 and every busy bit SHALL be cleared.
REQ-025 Reset SHALL take priority over any same-cycle write or issue.
REQ-026 During and immediately after reset, the outputs SHALL be:
- pend_cnt = 0
- busy1 = busy2 = 0
- rd1/rd2 = 0, except for same-cycle bypass.
REQ-027 Reset asserted mid-operation SHALL discard all pending state, and no later writeback SHALL be required to recover.

Verification
REQ-028 Bench: reset, then wea=1 waa=5 wda=0xDEADBEEF; the same cycle ra1=5 gives rd1=0xDEADBEEF via bypass; the next cycle with no write gives rd1=0xDEADBEEF from storage.
REQ-029 Bench: wea=web=1, waa=wab=7, wda=0x11, wdb=0x22 → rd1 at ra1=7 reads 0x22 in that cycle and thereafter.
REQ-030 Bench: write 0xFF to address 0 with ZERO_REG=1 → rd1=0; an issue to address 0 → pend_cnt stays 0.
REQ-031 Bench: issue to 3, then to 9 → pend_cnt=2 and busy1=1 at ra1=3; writeback wea=1 waa=3 → busy1=0 that cycle and pend_cnt=1 the next cycle.
REQ-032 Bench: iss_v=1 iss_dst=4 together with web=1 wab=4 → register 4 gets new data, busy[4]=1, and pend_cnt increments.
REQ-033 Bench: issue registers 1, 2 and 3, then assert reset with a write to register 2 in the same cycle → pend_cnt=0, busy=0, and all registers read 0.
